// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter for two requesters sharing one register bank.
// Each grant performs one write/set/clear/read on one word. The result is reported with a done pulse.
//
// state | meaning
// IDLE  | waiting for req_a/req_b; on a request, capture the winner and pulse its gnt
// EXEC  | apply the latched op to the bank and load rdata
// RESP  | winner's done (and err) high for this one cycle
module reg_bank_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [1:0]        op_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic              req_b,
  input  logic [1:0]        op_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic              err,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                capture, sel_b;
  logic                last_b;
  logic                lat_b;
  logic [1:0]          lat_op;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WIDTH-1:0]    lat_wdata;
  logic [WIDTH-1:0]    bank [DEPTH];
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    new_word;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    sel_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          capture = 1'b1;
          // on a tie the requester that did not win last time goes first
          sel_b   = req_b && (!req_a || !last_b);
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_range = ({{(32-ADDR_W){1'b0}}, lat_addr} < DEPTH_U);
  assign idx      = lat_addr[IDX_W-1:0];

  always_comb begin
    new_word = '0;
    if (in_range) begin
      case (lat_op)
        2'b00:   new_word = lat_wdata;
        2'b01:   new_word = '1;
        2'b10:   new_word = '0;
        default: new_word = bank[idx];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_b    <= 1'b1;
      lat_b     <= 1'b0;
      lat_op    <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      state_q <= state_d;
      gnt_a   <= capture && !sel_b;
      gnt_b   <= capture && sel_b;
      done_a  <= (state_q == EXEC) && !lat_b;
      done_b  <= (state_q == EXEC) && lat_b;
      err     <= (state_q == EXEC) && !in_range;
      if (capture) begin
        last_b    <= sel_b;
        lat_b     <= sel_b;
        lat_op    <= sel_b ? op_b    : op_a;
        lat_addr  <= sel_b ? addr_b  : addr_a;
        lat_wdata <= sel_b ? wdata_b : wdata_a;
      end
      if (state_q == EXEC) rdata <= new_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (state_q == EXEC && in_range) begin
      bank[idx] <= new_word;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (DEPTH=3, so address 3 is out of range).
// A cycle-scheduled model predicts every output and is compared on each falling edge.
module tb_reg_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [1:0] op_a = 2'b00, op_b = 2'b00;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [WIDTH-1:0] wdata_a = '0, wdata_b = '0;
  logic gnt_a, gnt_b, done_a, done_b, err, busy;
  logic [WIDTH-1:0] rdata;

  int checks_passed = 0;
  int checks_total = 0;
  bit run = 1'b0;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .op_a(op_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .op_b(op_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .err(err), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a capture at edge c gives gnt after c, done after c+1, idle after c+2; next capture no earlier than c+3.
  int e = 0;
  int cap_e = -10;
  int next_ok = 0;
  bit m_win_b = 1'b0;
  bit m_last_b = 1'b1;
  logic [1:0] m_op = '0;
  int m_addr = 0;
  logic [WIDTH-1:0] m_wd = '0;
  logic [WIDTH-1:0] mbank [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] m_rdata = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e = 0; cap_e = -10; next_ok = 0; m_win_b = 1'b0; m_last_b = 1'b1; m_rdata = '0;
      for (int i = 0; i < DEPTH; i++) mbank[i] = '0;
    end else begin
      e = e + 1;
      if (e == cap_e + 1) begin
        if (m_addr < DEPTH) begin
          case (m_op)
            2'b00: mbank[m_addr] = m_wd;
            2'b01: mbank[m_addr] = 8'hFF;
            2'b10: mbank[m_addr] = 8'h00;
            default: ;
          endcase
          m_rdata = mbank[m_addr];
        end else m_rdata = 8'h00;
      end
      if (e >= next_ok && (req_a || req_b)) begin
        m_win_b = (req_a && req_b) ? !m_last_b : req_b;
        m_last_b = m_win_b;
        m_op   = m_win_b ? op_b : op_a;
        m_addr = m_win_b ? int'(addr_b) : int'(addr_a);
        m_wd   = m_win_b ? wdata_b : wdata_a;
        cap_e = e;
        next_ok = e + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("gnt_a",  {31'b0, gnt_a},  {31'b0, (e == cap_e) && !m_win_b});
      chk("gnt_b",  {31'b0, gnt_b},  {31'b0, (e == cap_e) && m_win_b});
      chk("done_a", {31'b0, done_a}, {31'b0, (e == cap_e + 1) && !m_win_b});
      chk("done_b", {31'b0, done_b}, {31'b0, (e == cap_e + 1) && m_win_b});
      chk("err",    {31'b0, err},    {31'b0, (e == cap_e + 1) && (m_addr >= DEPTH)});
      chk("busy",   {31'b0, busy},   {31'b0, (e == cap_e) || (e == cap_e + 1)});
      chk("rdata",  {24'b0, rdata},  {24'b0, m_rdata});
    end
  end

  function automatic logic sigv(input int sel);
    case (sel)
      0: return gnt_a;
      1: return gnt_b;
      2: return done_a;
      default: return done_b;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input string name, output int cyc);
    cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      cyc++;
      if (sigv(sel) === 1'b1) return;
    end
    checks_total++;
    $display("FAIL timeout %s: got no pulse expected one within 30 cycles", name);
  endtask

  task automatic do_op(input bit b, input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd, output logic er);
    int c;
    if (b) begin req_b = 1; op_b = op; addr_b = addr; wdata_b = wd; end
    else   begin req_a = 1; op_a = op; addr_a = addr; wdata_a = wd; end
    wait_evt(b ? 1 : 0, "gnt", c);
    req_a = 0; req_b = 0;
    wait_evt(b ? 3 : 2, "done", c);
    chk("done_latency", c, 1);
    rd = rdata; er = err;
    @(negedge clk);
  endtask

  task automatic tie_once(output bit first_b);
    first_b = 0;
    req_a = 1; op_a = 2'b11; addr_a = 2'd1;
    req_b = 1; op_b = 2'b11; addr_b = 2'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin first_b = gnt_b; break; end
    end
    req_a = 0; req_b = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    logic er;
    bit fb;
    int c;
    int seq;
    int ngnt;

    #3 reset = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    run = 1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rdata", {24'b0, rdata}, 0);

    // A writes 0x5A to addr 1, B reads it back
    do_op(0, 2'b00, 2'd1, 8'h5A, rd, er);
    chk("wr_a_rdata", {24'b0, rd}, 32'h5A);
    do_op(1, 2'b11, 2'd1, 8'h00, rd, er);
    chk("rd_b_rdata", {24'b0, rd}, 32'h5A);

    // simultaneous held requests: A set addr0, then B clear addr0
    req_a = 1; op_a = 2'b01; addr_a = 2'd0;
    req_b = 1; op_b = 2'b10; addr_b = 2'd0;
    wait_evt(0, "tie_gnt_a", c);
    req_a = 0;
    wait_evt(2, "tie_done_a", c);
    chk("tie_a_rdata", {24'b0, rdata}, 32'hFF);
    wait_evt(1, "tie_gnt_b", c);
    chk("tie_b_gap", c, 2);
    req_b = 0;
    wait_evt(3, "tie_done_b", c);
    chk("tie_b_rdata", {24'b0, rdata}, 32'h00);
    @(negedge clk);

    tie_once(fb); chk("tie1_winner_b", {31'b0, fb}, 0);
    tie_once(fb); chk("tie2_winner_b", {31'b0, fb}, 1);
    tie_once(fb); chk("tie3_winner_b", {31'b0, fb}, 0);

    // out-of-range write must leave the bank alone
    do_op(0, 2'b00, 2'd2, 8'h77, rd, er);
    do_op(0, 2'b00, 2'd3, 8'h33, rd, er);
    chk("oor_err", {31'b0, er}, 1);
    chk("oor_rdata", {24'b0, rd}, 0);
    do_op(1, 2'b11, 2'd0, 8'h00, rd, er); chk("oor_rd0", {24'b0, rd}, 32'h00);
    do_op(1, 2'b11, 2'd1, 8'h00, rd, er); chk("oor_rd1", {24'b0, rd}, 32'h5A);
    chk("inrange_err", {31'b0, er}, 0);
    do_op(1, 2'b11, 2'd2, 8'h00, rd, er); chk("oor_rd2", {24'b0, rd}, 32'h77);

    // reset during EXEC of a write 0xFF to addr 2
    req_a = 1; op_a = 2'b00; addr_a = 2'd2; wdata_a = 8'hFF;
    wait_evt(0, "rst_gnt", c);
    req_a = 0;
    #2 reset = 0;
    #1 chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_done", {31'b0, done_a}, 0);
    @(negedge clk);
    #2 reset = 1;
    @(negedge clk);
    do_op(1, 2'b11, 2'd2, 8'h00, rd, er); chk("rst_rd2", {24'b0, rd}, 32'h00);

    // A holds req, B requests once: grants A, B, A
    req_a = 1; op_a = 2'b00; addr_a = 2'd0; wdata_a = 8'h11;
    seq = 0; ngnt = 0;
    for (int k = 0; k < 40 && ngnt < 3; k++) begin
      @(negedge clk);
      if (gnt_a) begin
        seq = seq * 4 + 1; ngnt++;
        if (ngnt == 1) begin req_b = 1; op_b = 2'b01; addr_b = 2'd1; end
      end
      if (gnt_b) begin seq = seq * 4 + 2; ngnt++; req_b = 0; end
    end
    req_a = 0;
    chk("rr_order", seq, 32'h19);
    repeat (4) @(negedge clk);
    chk("final_busy", {31'b0, busy}, 0);

    run = 0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
